// File: rtl/mem_port_arbiter.sv
// Single memory port shared by fetch and load/store; data wins unless fetch is owed a turn.
// Request-to-done is 3 cycles plus one per wait state; the stall is held until the completion pulse.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_rd_en,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  inst_valid,
  input  logic                  data_rd_en,
  input  logic                  data_wr_en,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wr_data,
  output logic [DATA_WIDTH-1:0] data_rd_data,
  output logic                  data_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  mem_stall,
  output logic                  bus_error
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, DATA, INST} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_wait;
  logic                  r_fair;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_inst_data;
  logic                  r_inst_valid;
  logic [DATA_WIDTH-1:0] r_data_rd_data;
  logic                  r_data_done;
  logic                  r_bus_error;

  logic w_data_elig;
  logic w_inst_elig;
  logic w_pick_inst;
  logic w_timeout;
  logic w_finish;

  // A requester whose completion pulse is showing is still holding its enable; skip it.
  assign w_data_elig = (data_rd_en | data_wr_en) & ~r_data_done;
  assign w_inst_elig = inst_rd_en & ~r_inst_valid;
  assign w_pick_inst = w_inst_elig & (~w_data_elig | r_fair);
  assign w_timeout   = ~mem_ack & (r_wait == CNT_W'(MAX_WAIT - 1));
  assign w_finish    = mem_ack | w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_wait         <= '0;
      r_fair         <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_inst_data    <= '0;
      r_inst_valid   <= 1'b0;
      r_data_rd_data <= '0;
      r_data_done    <= 1'b0;
      r_bus_error    <= 1'b0;
    end else begin
      r_inst_valid <= 1'b0;
      r_data_done  <= 1'b0;
      r_bus_error  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_inst) begin
            r_state     <= INST;
            r_wait      <= '0;
            r_fair      <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= inst_addr;
            r_mem_wdata <= '0;
          end else if (w_data_elig) begin
            // rd and wr together is treated as a store
            r_state     <= DATA;
            r_wait      <= '0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= data_wr_en;
            r_mem_addr  <= data_addr;
            r_mem_wdata <= data_wr_data;
          end
        end
        DATA, INST: begin
          if (w_finish) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_bus_error <= w_timeout;
            if (r_state == DATA) begin
              r_data_done <= 1'b1;
              if (w_timeout)
                r_data_rd_data <= '0;
              else if (!r_mem_we)
                r_data_rd_data <= mem_rdata;
              if (inst_rd_en)
                r_fair <= 1'b1;
            end else begin
              r_inst_valid <= 1'b1;
              r_inst_data  <= w_timeout ? '0 : mem_rdata;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign inst_data    = r_inst_data;
  assign inst_valid   = r_inst_valid;
  assign data_rd_data = r_data_rd_data;
  assign data_done    = r_data_done;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign bus_error    = r_bus_error;
  assign mem_stall    = (inst_rd_en & ~r_inst_valid) | ((data_rd_en | data_wr_en) & ~r_data_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random transactions against mem_port_arbiter; bench plays both requesters and the memory.
module tb_mem_port_arbiter;

  localparam int MAXW = 4;

  logic        clk;
  logic        rst_n;
  logic        inst_rd_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_valid;
  logic        data_rd_en;
  logic        data_wr_en;
  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [31:0] data_rd_data;
  logic        data_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_stall;
  logic        bus_error;

  int n_vec = 0;
  int n_err = 0;

  // Last value each requester should see on its read-data output.
  logic [31:0] exp_inst;
  logic [31:0] exp_drd;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_rd_en(inst_rd_en), .inst_addr(inst_addr), .inst_data(inst_data), .inst_valid(inst_valid),
    .data_rd_en(data_rd_en), .data_wr_en(data_wr_en), .data_addr(data_addr),
    .data_wr_data(data_wr_data), .data_rd_data(data_rd_data), .data_done(data_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      inst_rd_en = 1'b0; data_rd_en = 1'b0; data_wr_en = 1'b0; mem_ack = 1'b0;
      sample();
      chk1("idle_req", mem_req, 1'b0);
      chk1("idle_stall", mem_stall, 1'b0);
    end
  endtask

  // kind: 0 fetch, 1 load, 2 store, 3 load+store (behaves as store)
  task automatic access(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata);
    bit is_inst, is_wr, tmo;
    int nreq;
    is_inst = (kind == 0);
    is_wr   = (kind >= 2);
    tmo     = (waits >= MAXW);
    nreq    = tmo ? MAXW : waits + 1;
    next_cycle();
    inst_rd_en   = is_inst;
    data_rd_en   = (kind == 1) || (kind == 3);
    data_wr_en   = is_wr;
    inst_addr    = is_inst ? addr : ~addr;
    data_addr    = is_inst ? ~addr : addr;
    data_wr_data = wdata;
    mem_ack      = 1'b0;
    sample();
    chk1("req_cycle_mem_req", mem_req, 1'b0);
    chk1("req_cycle_stall", mem_stall, 1'b1);
    for (int k = 0; k < nreq; k++) begin
      next_cycle();
      mem_ack   = !tmo && (k == waits);
      mem_rdata = mem_ack ? rdata : ~rdata;
      sample();
      chk1("bus_mem_req", mem_req, 1'b1);
      chk1("bus_mem_we", mem_we, is_wr);
      chkw("bus_mem_addr", mem_addr, addr);
      if (!is_inst) chkw("bus_mem_wdata", mem_wdata, wdata);
      chk1("bus_stall", mem_stall, 1'b1);
      chk1("bus_no_done", data_done | inst_valid, 1'b0);
    end
    if (is_inst) exp_inst = tmo ? 32'h0 : rdata;
    else if (!is_wr) exp_drd = tmo ? 32'h0 : rdata;
    else if (tmo) exp_drd = 32'h0;
    next_cycle();
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    sample();
    chk1("done_inst_valid", inst_valid, is_inst);
    chk1("done_data_done", data_done, !is_inst);
    chk1("done_bus_error", bus_error, tmo);
    chk1("done_mem_req", mem_req, 1'b0);
    chk1("done_stall", mem_stall, 1'b0);
    chkw("done_inst_data", inst_data, exp_inst);
    chkw("done_data_rd_data", data_rd_data, exp_drd);
  endtask

  initial begin
    rst_n = 1'b0; inst_rd_en = 1'b0; data_rd_en = 1'b0; data_wr_en = 1'b0;
    inst_addr = '0; data_addr = '0; data_wr_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    exp_inst = '0; exp_drd = '0;
    repeat (2) sample();
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chkw("rst_mem_addr", mem_addr, 32'h0);
    chkw("rst_mem_wdata", mem_wdata, 32'h0);
    chkw("rst_inst_data", inst_data, 32'h0);
    chkw("rst_data_rd_data", data_rd_data, 32'h0);
    chk1("rst_pulses", inst_valid | data_done | bus_error, 1'b0);
    chk1("rst_stall", mem_stall, 1'b0);
    rst_n = 1'b1;

    // zero-wait fetch, load, then store with 3 waits leaving load data intact
    access(0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    access(1, 32'h24, 32'h0, 1, 32'hCAFE0123);
    access(2, 32'h20, 32'h55AA, 3, 32'h77777777);
    idle(1);

    // simultaneous load and fetch; fairness hands the next slot to fetch
    next_cycle();
    inst_rd_en = 1'b1; inst_addr = 32'h400; data_rd_en = 1'b1; data_wr_en = 1'b0; data_addr = 32'h800;
    sample();
    chk1("sim_c0_req", mem_req, 1'b0);
    next_cycle(); mem_ack = 1'b1; mem_rdata = 32'h11110001;
    sample();
    chkw("sim_load_first", mem_addr, 32'h800);
    chk1("sim_load_we", mem_we, 1'b0);
    next_cycle(); mem_ack = 1'b0; mem_rdata = $urandom;
    sample();
    chk1("sim_load_done", data_done, 1'b1);
    chkw("sim_load_data", data_rd_data, 32'h11110001);
    chk1("sim_fetch_still_stalls", mem_stall, 1'b1);
    next_cycle(); data_addr = 32'h804; mem_ack = 1'b1; mem_rdata = 32'h22220002;
    sample();
    chk1("sim_fetch_req", mem_req, 1'b1);
    chkw("sim_fetch_second", mem_addr, 32'h400);
    next_cycle(); mem_ack = 1'b0; mem_rdata = $urandom;
    sample();
    chk1("sim_fetch_valid", inst_valid, 1'b1);
    chkw("sim_fetch_data", inst_data, 32'h22220002);
    next_cycle(); inst_addr = 32'h408; mem_ack = 1'b1; mem_rdata = 32'h33330003;
    sample();
    chkw("sim_load_again_first", mem_addr, 32'h804);
    next_cycle(); mem_ack = 1'b0; mem_rdata = $urandom;
    sample();
    chk1("sim_load2_done", data_done, 1'b1);
    chkw("sim_load2_data", data_rd_data, 32'h33330003);
    next_cycle(); data_rd_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h44440004;
    sample();
    chkw("sim_fetch2_addr", mem_addr, 32'h408);
    next_cycle(); mem_ack = 1'b0; mem_rdata = $urandom;
    sample();
    chk1("sim_fetch2_valid", inst_valid, 1'b1);
    chkw("sim_fetch2_data", inst_data, 32'h44440004);
    chk1("sim_fetch2_stall", mem_stall, 1'b0);
    exp_inst = 32'h44440004; exp_drd = 32'h33330003;
    idle(1);

    // timeout on a load, then a normal fetch
    access(1, 32'h30, 32'h0, MAXW, 32'h12345678);
    access(0, 32'h104, 32'h0, 0, 32'hA5A5A5A5);
    idle(2);

    // back-to-back loads with a new address right after done
    access(1, 32'h40, 32'h0, 0, 32'h0BADF00D);
    access(1, 32'h44, 32'h0, 1, 32'hFEEDFACE);
    idle(1);

    // reset during the second wait cycle of a fetch
    next_cycle(); inst_rd_en = 1'b1; inst_addr = 32'h200; mem_ack = 1'b0;
    sample();
    next_cycle();
    sample();
    chk1("rstmid_wait1_req", mem_req, 1'b1);
    next_cycle();
    #2; rst_n = 1'b0; inst_rd_en = 1'b0;
    #1;
    chk1("rstmid_mem_req", mem_req, 1'b0);
    chkw("rstmid_mem_addr", mem_addr, 32'h0);
    chkw("rstmid_inst_data", inst_data, 32'h0);
    chkw("rstmid_data_rd_data", data_rd_data, 32'h0);
    chk1("rstmid_stall", mem_stall, 1'b0);
    next_cycle(); mem_ack = 1'b1; mem_rdata = 32'h99999999;
    sample();
    chk1("rstmid_hold_req", mem_req, 1'b0);
    rst_n = 1'b1;
    next_cycle(); mem_ack = 1'b1;
    sample();
    chk1("late_ack_req", mem_req, 1'b0);
    next_cycle(); mem_ack = 1'b0;
    sample();
    chk1("late_ack_no_valid", inst_valid, 1'b0);
    chkw("late_ack_inst_data", inst_data, 32'h0);
    exp_inst = '0; exp_drd = '0;
    access(0, 32'h208, 32'h0, 2, 32'h13572468);

    // random single-requester traffic, including timeouts and rd+wr stores
    for (int t = 0; t < 40; t++) begin
      access(int'($urandom_range(0, 3)), $urandom, $urandom, int'($urandom_range(0, 5)), $urandom);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Serialises the two requesters and inserts wait states for slow memory.
- Drives a pipeline stall toward the core control logic while any request is outstanding.
- Sits between the IF/MEM stages and the external single-port memory bus.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- MAX_WAIT, 255, wait cycles allowed per access before the access is aborted. Legal range 1..1023.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- inst_rd_en  input  1  fetch request; held high until inst_valid.
- inst_addr  input  ADDR_WIDTH  fetch address; stable while inst_rd_en is high.
- inst_data  output  DATA_WIDTH  fetched word; valid when inst_valid is high.
- inst_valid  output  1  one-cycle fetch completion pulse.
- data_rd_en  input  1  load request; held high until data_done.
- data_wr_en  input  1  store request; held high until data_done.
- data_addr  input  ADDR_WIDTH  load/store address.
- data_wr_data  input  DATA_WIDTH  store data.
- data_rd_data  output  DATA_WIDTH  load result; valid when data_done is high.
- data_done  output  1  one-cycle load/store completion pulse.
- mem_req  output  1  bus request; registered.
- mem_we  output  1  bus write enable; registered.
- mem_addr  output  ADDR_WIDTH  bus address; registered.
- mem_wdata  output  DATA_WIDTH  bus write data; registered.
- mem_rdata  input  DATA_WIDTH  bus read data; sampled when mem_ack is high.
- mem_ack  input  1  bus completion, one cycle.
- mem_stall  output  1  combinational; freezes the pipeline.
- bus_error  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: asynchronous on rst_n low. Takes effect immediately, including mid-access.
  - State = IDLE, wait counter = 0, fairness flag = 0.
  - All registered outputs = 0, including data buses.
  - An access in flight is dropped with no done pulse. mem_ack arriving during or after reset is ignored.
- FSM states: IDLE, DATA, INST.
- IDLE:
  - A requester is eligible if its enable is high and its own done/valid is NOT high this cycle. This prevents re-issuing a just-completed access.
  - Data request (rd or wr) eligible → DATA. Else inst eligible → INST. Else stay in IDLE.
  - If both are eligible and the fairness flag is 1, INST wins. The flag is then cleared.
  - The fairness flag is set when a DATA access completes with inst_rd_en high; it is cleared when an INST grant is made.
- Grant (IDLE → DATA or INST), next cycle:
  - mem_req = 1; mem_addr and mem_wdata are loaded from the granted requester.
  - mem_we = data_wr_en for DATA, 0 for INST.
  - data_rd_en and data_wr_en both high is illegal; it is treated as a store.
- DATA / INST:
  - mem_req and the bus registers are held stable.
  - The wait counter increments each cycle without mem_ack.
  - On mem_ack: mem_req/mem_we = 0, mem_rdata is latched into data_rd_data (loads) or inst_data (INST), state → IDLE. data_done or inst_valid is high for exactly the next cycle.
  - Store completion does not modify data_rd_data.
  - If the counter reaches MAX_WAIT with no ack: drop mem_req, drive the granted requester's read data to 0, pulse its done/valid and bus_error together, state → IDLE.
  - The counter clears on every grant.
- Latency: minimum request-to-done is 3 cycles.
  - Request sampled in IDLE at cycle N, mem_req high at N+1, ack at N+1, done at N+2.
  - Each extra wait cycle adds 1.
- mem_stall = (inst_rd_en & ~inst_valid) | ((data_rd_en | data_wr_en) & ~data_done).
  - Low in the completion cycle so the pipeline advances exactly once per access.
- mem_ack while in IDLE is ignored.
- mem_rdata is only sampled in a cycle where mem_ack is high.

Test Plan:
- Zero-wait fetch: inst_rd_en=1, inst_addr=0x100; ack on the first mem_req cycle with mem_rdata=0xDEADBEEF → mem_req for 1 cycle with mem_we=0; inst_valid 2 cycles after request with inst_data=0xDEADBEEF; mem_stall high for 2 cycles then low.
- Store with 3 wait states: data_wr_en=1, addr=0x20, data=0x55AA → mem_we=1, mem_wdata=0x55AA held 4 cycles; data_done one cycle after ack; data_rd_data unchanged.
- Simultaneous requests:
  - Load and fetch both asserted, fairness flag 0 → load served first. Flag set → fetch served next, even with a new load pending.
  - Following that fetch, if both are asserted again → load served first again (flag clear).
- Timeout: MAX_WAIT=4, load issued, mem_ack never asserted → mem_req drops after 4 wait cycles; data_done and bus_error pulse together; data_rd_data=0; FSM back to IDLE and accepts the next fetch.
- Reset mid-access: rst_n low during the 2nd wait cycle of a fetch → all outputs 0 immediately; late mem_ack after release yields no inst_valid; a new request after release is served normally.
- Back-to-back loads: the requester presents a new data_addr in the cycle after data_done → no duplicate access for the old address; second grant follows in IDLE.
